// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the line buffer controller: FSM encoding and the
// number of complete windows a frame produces.
package line_buffer_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ctrl_state_e;

  function automatic int window_count(input int line_length, input int num_lines,
                                      input int window_width, input int frame_lines);
    return (line_length - window_width + 1) * (frame_lines - num_lines + 1);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_raster_counter.sv
// Raster position counter: column wraps at the end of a line, row wraps at the
// end of a frame. A clear together with inc counts the cleared pixel as (0,0).
module raster_counter #(
  parameter int LINE_LENGTH = 20,
  parameter int FRAME_LINES = 16,
  localparam int XW = $clog2(LINE_LENGTH),
  localparam int YW = $clog2(FRAME_LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last_col,
  output logic          last_pix
);

  localparam logic [XW-1:0] LAST_X = XW'(LINE_LENGTH - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(FRAME_LINES - 1);

  logic [XW-1:0] x_q, x_d, x_base;
  logic [YW-1:0] y_q, y_d, y_base;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    x_base = clear ? '0 : x_q;
    y_base = clear ? '0 : y_q;
    x_d    = x_base;
    y_d    = y_base;
    if (inc) begin
      if (x_base == LAST_X) begin
        x_d = '0;
        y_d = (y_base == LAST_Y) ? '0 : y_base + 1'b1;
      end else begin
        x_d = x_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign last_col = (x_q == LAST_X);
  assign last_pix = last_col && (y_q == LAST_Y);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Controller for the line buffer window datapath: accepts raster pixels, drives
// the shift enable, and presents qualified window coordinates with back-pressure.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int LINE_LENGTH  = 20,
  parameter int NUM_LINES    = 10,
  parameter int WINDOW_WIDTH = 10,
  parameter int FRAME_LINES  = 16,
  parameter int X_BITS       = $clog2(LINE_LENGTH),
  parameter int Y_BITS       = $clog2(FRAME_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              shift_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [X_BITS-1:0] win_x,
  output logic [Y_BITS-1:0] win_y,
  output logic              win_eof,
  output logic              frame_done,
  output logic              sof_err
);

  localparam logic [X_BITS-1:0] X_OFF  = X_BITS'(WINDOW_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_OFF  = Y_BITS'(NUM_LINES - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(FRAME_LINES - 1);

  ctrl_state_e       state_q;
  logic              win_valid_q;
  logic [X_BITS-1:0] win_x_q;
  logic [Y_BITS-1:0] win_y_q;
  logic              win_eof_q;
  logic              frame_done_q;
  logic              sof_err_q;

  logic [X_BITS-1:0] cnt_x;
  logic [Y_BITS-1:0] cnt_y;
  logic              cnt_last_col;
  logic              cnt_last_pix;

  logic              accept;
  logic              restart;
  logic [X_BITS-1:0] pix_x;
  logic [Y_BITS-1:0] pix_y;
  logic              qualify;
  logic              pix_eof;
  logic              frame_end;
  logic              bad_sof;

  // A held window blocks input so the line buffer contents stay put under it.
  assign in_ready = rst & (~win_valid_q | win_ready);
  assign accept   = in_valid & in_ready;
  assign shift_en = accept & ((state_q == ACTIVE) | in_sof);
  assign restart  = shift_en & in_sof;

  assign pix_x     = in_sof ? '0 : cnt_x;
  assign pix_y     = in_sof ? '0 : cnt_y;
  assign qualify   = shift_en & (pix_x >= X_OFF) & (pix_y >= Y_OFF);
  assign pix_eof   = ~in_sof & cnt_last_col & (cnt_y == Y_LAST);
  assign frame_end = shift_en & ~in_sof & cnt_last_pix;
  assign bad_sof   = accept & (((state_q == IDLE) & ~in_sof) | ((state_q == ACTIVE) & in_sof));

  raster_counter #(
    .LINE_LENGTH(LINE_LENGTH),
    .FRAME_LINES(FRAME_LINES)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .inc     (shift_en),
    .clear   (restart),
    .x       (cnt_x),
    .y       (cnt_y),
    .last_col(cnt_last_col),
    .last_pix(cnt_last_pix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      sof_err_q    <= bad_sof;

      case (state_q)
        IDLE:    if (shift_en) state_q <= ACTIVE;
        ACTIVE:  if (frame_end) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A new qualifying pixel wins over a same-cycle release.
      if (qualify) begin
        win_valid_q <= 1'b1;
        win_x_q     <= pix_x - X_OFF;
        win_y_q     <= pix_y - Y_OFF;
        win_eof_q   <= pix_eof;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_eof    = win_eof_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: directed scenarios plus random
// handshake gaps, checked each cycle against a pixel-index reference model.
module tb_line_buffer_ctrl;
  import line_buffer_ctrl_pkg::*;

  localparam int LL  = 20;
  localparam int NL  = 10;
  localparam int WW  = 10;
  localparam int FL  = 16;
  localparam int XB  = $clog2(LL);
  localparam int YB  = $clog2(FL);
  localparam int WPF = window_count(LL, NL, WW, FL);
  localparam int COLS = LL - WW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          win_ready = 1'b0;
  logic          in_ready, shift_en, win_valid, win_eof, frame_done, sof_err;
  logic [XB-1:0] win_x;
  logic [YB-1:0] win_y;

  line_buffer_ctrl #(
    .LINE_LENGTH(LL), .NUM_LINES(NL), .WINDOW_WIDTH(WW), .FRAME_LINES(FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_eof   (win_eof),
    .frame_done(frame_done),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position as a linear pixel index.
  bit m_active, m_wv, m_eof, m_fd, m_se, m_last_shift;
  int m_pos, m_wx, m_wy, m_frames;

  int lx[$], ly[$], le[$];
  int shifts_seen, first_win_at, frame_done_seen, sof_err_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wv = 0; m_eof = 0; m_fd = 0; m_se = 0; m_last_shift = 0;
    m_pos = 0; m_wx = 0; m_wy = 0;
  endtask

  task automatic clear_log();
    lx.delete(); ly.delete(); le.delete();
    shifts_seen = 0;
    first_win_at = -1;
  endtask

  // Called at a falling edge: drive, sample, advance model, wait for next falling edge.
  task automatic cycle(input bit v, input bit s, input bit wr);
    bit m_ready, acc, shift, nwv, nfd, nse;
    int pos, px, py;
    pos = 0;
    in_valid = v; in_sof = s; win_ready = wr;
    #1;
    m_ready = !m_wv || wr;
    acc     = v && m_ready;
    shift   = acc && (m_active || s);
    check("in_ready",   32'(in_ready),   32'(m_ready));
    check("shift_en",   32'(shift_en),   32'(shift));
    check("win_valid",  32'(win_valid),  32'(m_wv));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("sof_err",    32'(sof_err),    32'(m_se));
    if (m_wv) begin
      check("win_x",   32'(win_x),   32'(m_wx));
      check("win_y",   32'(win_y),   32'(m_wy));
      check("win_eof", 32'(win_eof), 32'(m_eof));
    end
    if (win_valid === 1'b1 && first_win_at < 0) first_win_at = shifts_seen;
    if (win_valid === 1'b1 && wr) begin
      lx.push_back(int'(win_x)); ly.push_back(int'(win_y)); le.push_back(int'(win_eof));
    end
    if (shift_en === 1'b1) shifts_seen++;
    if (frame_done === 1'b1) frame_done_seen++;
    if (sof_err === 1'b1) sof_err_seen++;

    nwv = m_wv && !wr; nfd = 0; nse = 0;
    if (acc) begin
      if (s) begin
        nse = m_active;
        pos = 0;
      end else if (!m_active) begin
        nse = 1;
      end else begin
        pos = m_pos;
      end
    end
    if (shift) begin
      px = pos % LL;
      py = pos / LL;
      if (px >= WW - 1 && py >= NL - 1) begin
        nwv = 1; m_wx = px - (WW - 1); m_wy = py - (NL - 1); m_eof = (pos == LL * FL - 1);
      end
      if (pos == LL * FL - 1) begin
        m_active = 0; m_pos = 0; nfd = 1; m_frames++;
      end else begin
        m_active = 1; m_pos = pos + 1;
      end
    end
    m_wv = nwv; m_fd = nfd; m_se = nse; m_last_shift = shift;
    @(negedge clk);
  endtask

  // Called at a falling edge; reset is applied between clock edges.
  task automatic do_reset();
    in_valid = 1; in_sof = 1; win_ready = 1;
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_shift_en",   32'(shift_en),   32'd0);
    check("rst_win_valid",  32'(win_valid),  32'd0);
    check("rst_win_x",      32'(win_x),      32'd0);
    check("rst_win_y",      32'(win_y),      32'd0);
    check("rst_win_eof",    32'(win_eof),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sof_err",    32'(sof_err),    32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    in_valid = 0; in_sof = 0;
    rst = 1'b1;
  endtask

  // One frame at full rate; optional mid-frame sof and optional hold on window (3,2).
  task automatic run_frame(input int restart_at, input bit do_hold);
    int pix, hold, guard;
    bit s, wr;
    pix = 0; hold = 0; guard = 0;
    do begin
      s = (pix == 0) || (pix == restart_at);
      if (pix == restart_at) begin
        shifts_seen = 0;
        first_win_at = -1;
      end
      wr = 1'b1;
      if (do_hold && m_wv && m_wx == 3 && m_wy == 2 && hold < 5) begin
        wr = 1'b0;
        hold++;
      end
      cycle(1'b1, s, wr);
      if (m_last_shift) pix++;
      guard++;
    end while (m_active && guard < 2000);
    check("frame_budget", 32'(guard < 2000), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic compare_log(input int frames);
    int n, k;
    n = frames * WPF;
    check("win_count", 32'(lx.size()), 32'(n));
    for (int i = 0; i < lx.size() && i < n; i++) begin
      k = i % WPF;
      check("seq_x",   32'(lx[i]), 32'(k % COLS));
      check("seq_y",   32'(ly[i]), 32'(k / COLS));
      check("seq_eof", 32'(le[i]), 32'(k == WPF - 1));
    end
  endtask

  initial begin
    int fd0, se0, sh0, guard;
    bit v, wr;
    frame_done_seen = 0; sof_err_seen = 0; m_frames = 0;
    model_reset();
    clear_log();
    do_reset();

    // Full frame, consumer always ready.
    clear_log(); fd0 = frame_done_seen;
    run_frame(-1, 1'b0);
    check("first_win_latency", 32'(first_win_at), 32'd190);
    compare_log(1);
    if (lx.size() > 0) begin
      check("last_win_x", 32'(lx[lx.size()-1]), 32'd10);
      check("last_win_y", 32'(ly[ly.size()-1]), 32'd6);
    end
    check("frame_done_pulses", 32'(frame_done_seen - fd0), 32'd1);

    // Consumer stalls on window (3,2) for five cycles.
    clear_log();
    run_frame(-1, 1'b1);
    compare_log(1);

    // Pixels without sof while idle are discarded with an error pulse each.
    se0 = sof_err_seen; sh0 = shifts_seen;
    repeat (4) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("idle_sof_err_pulses", 32'(sof_err_seen - se0), 32'd4);
    check("idle_no_shift", 32'(shifts_seen - sh0), 32'd0);

    // Mid-frame sof at pixel 150 restarts the frame.
    clear_log(); se0 = sof_err_seen;
    run_frame(150, 1'b0);
    check("restart_sof_err", 32'(sof_err_seen - se0), 32'd1);
    check("restart_first_win", 32'(first_win_at), 32'd190);
    compare_log(1);

    // Reset after 200 pixels while a window is presented.
    clear_log();
    for (int i = 0; i < 200; i++) cycle(1'b1, i == 0, 1'b1);
    check("pre_reset_win_valid", 32'(win_valid), 32'd1);
    do_reset();
    clear_log(); fd0 = frame_done_seen;
    run_frame(-1, 1'b0);
    check("post_reset_first_win", 32'(first_win_at), 32'd190);
    compare_log(1);
    check("post_reset_frame_done", 32'(frame_done_seen - fd0), 32'd1);

    // Three frames with random input gaps and consumer stalls.
    clear_log(); fd0 = frame_done_seen; m_frames = 0; guard = 0;
    while (frame_done_seen - fd0 < 3 && guard < 20000) begin
      v  = ($urandom_range(0, 3) != 0) && (m_frames < 3);
      wr = ($urandom_range(0, 2) != 0);
      cycle(v, !m_active, wr);
      guard++;
    end
    check("random_budget", 32'(guard < 20000), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    compare_log(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
